data_memory_ctrl: RTL

//  Parametrised successor data memory for the MIPS32 datapath: byte-addressed, req/ready handshake,

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_lane_align.sv | 46 ++++
 rtl/data_memory_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data memory controller: access sizes, FSM states,
// wait-state counter width and the per-lane parity helper.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int WS_CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } dmem_state_e;

  // Even parity per byte lane: bit i is the XOR of byte i.
  function automatic logic [3:0] lane_parity(input logic [31:0] w);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) begin
      p[i] = ^w[8*i +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: byte enables, store replication, load extraction
// with sign/zero extension, and misalignment detection (little-endian lanes).
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        unsigned_ld_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_rep_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted      = rword_i >> {addr_lo_i, 3'b000};
    be_o         = 4'b1111;
    wdata_rep_o  = wdata_i;
    rdata_o      = rword_i;
    misaligned_o = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        be_o        = 4'b0001 << addr_lo_i;
        wdata_rep_o = {4{wdata_i[7:0]}};
        rdata_o     = unsigned_ld_i ? {24'h0, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_rep_o  = {2{wdata_i[15:0]}};
        rdata_o      = unsigned_ld_i ? {16'h0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
        misaligned_o = addr_lo_i[0];
      end
      // Word and the reserved encoding both behave as a full-word access.
      default: begin
        misaligned_o = |addr_lo_i;
      end
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory with req/ready handshake and programmable wait states.
// Optional per-lane even parity storage/check when DMEM_PARITY_EN is defined.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int WAIT_STATES = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [31:0]       write_data,
  output logic              ready,
  output logic              resp_valid,
  output logic [31:0]       read_data,
  output logic              misaligned,
  output logic              parity_err
);

  localparam int DEPTH   = 2 ** (ADDR_W - 2);
  localparam int WS_LOAD = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

  dmem_state_e         state_q, state_d;
  logic [WS_CNT_W-1:0] cnt_q, cnt_d;
  logic                rst_done_q;
  logic                accept;

  logic                we_q, uns_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          size_q;
  logic [31:0]         wdata_q;

  logic [31:0]         mem_q [DEPTH];
  logic [31:0]         rword_q;
  logic [ADDR_W-3:0]   word_idx;

  logic [3:0]          be;
  logic [31:0]         wdata_rep, rdata_ext;
  logic                mis, par_err_now, do_write, do_read;

  logic                resp_valid_q, misaligned_q, parity_err_q;
  logic [31:0]         read_data_q;

  // Handshake: a request is accepted on the rising edge where req && ready;
  // ready is high only in IDLE after reset release, and the one-cycle
  // resp_valid pulse carries read_data/misaligned/parity_err for that access.
  assign ready    = (state_q == S_IDLE) && rst_done_q;
  assign word_idx = addr_q[ADDR_W-1:2];
  assign do_write = (state_q == S_ACCESS) && we_q && !mis;
  assign do_read  = (state_q == S_ACCESS) && !we_q && !mis;

  dmem_lane_align u_align (
    .size_i        (size_q),
    .addr_lo_i     (addr_q[1:0]),
    .unsigned_ld_i (uns_q),
    .wdata_i       (wdata_q),
    .rword_i       (rword_q),
    .be_o          (be),
    .wdata_rep_o   (wdata_rep),
    .rdata_o       (rdata_ext),
    .misaligned_o  (mis)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req && ready) begin
          accept = 1'b1;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WS_CNT_W'(WS_LOAD);
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_ACCESS;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rst_done_q   <= 1'b0;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      size_q       <= SZ_WORD;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      read_data_q  <= '0;
      misaligned_q <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rst_done_q <= 1'b1;
      if (accept) begin
        we_q    <= we;
        uns_q   <= unsigned_ld;
        addr_q  <= addr;
        size_q  <= size;
        wdata_q <= write_data;
      end
      resp_valid_q <= (state_q == S_RESP);
      read_data_q  <= ((state_q == S_RESP) && !we_q && !mis) ? rdata_ext : '0;
      misaligned_q <= (state_q == S_RESP) && mis;
      parity_err_q <= (state_q == S_RESP) && par_err_now;
    end
  end

  // Array contents survive reset; a reset before the ACCESS edge forces IDLE,
  // so a dropped request never reaches the array.
  always_ff @(posedge clock) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
    if (do_read) rword_q <= mem_q[word_idx];
  end

`ifdef DMEM_PARITY_EN
  logic [3:0] par_mem_q [DEPTH];
  logic [3:0] rpar_q;

  always_ff @(posedge clock) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) par_mem_q[word_idx][i] <= ^wdata_rep[8*i +: 8];
      end
    end
    if (do_read) rpar_q <= par_mem_q[word_idx];
  end

  assign par_err_now = !we_q && !mis && |(be & (lane_parity(rword_q) ^ rpar_q));
`else
  assign par_err_now = 1'b0;
`endif

  assign resp_valid = resp_valid_q;
  assign read_data  = read_data_q;
  assign misaligned = misaligned_q;
  assign parity_err = parity_err_q;

endmodule
